// File: rtl/reg_pkg.sv
// Generic 32-bit register-bus request/response types.
package reg_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_rsp_t;

endpackage

// File: rtl/sbox_lut_loader_pkg.sv
// Shared types and constants for the S-box LUT loader.
package sbox_lut_loader_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StWrite,
      StRead,
      StDone
   } loader_state_e;

   localparam int unsigned AsconEntries = 32;

   // Ascon 5-bit S-box, entry i in bits [5i+4:5i] (rightmost literal is entry 0).
   localparam logic [AsconEntries*5-1:0] AsconSbox = {
      5'h17, 5'h0f, 5'h0a, 5'h16, 5'h19, 5'h01, 5'h0c, 5'h10,
      5'h18, 5'h11, 5'h0d, 5'h00, 5'h0e, 5'h07, 5'h13, 5'h1e,
      5'h1c, 5'h06, 5'h03, 5'h1d, 5'h12, 5'h08, 5'h05, 5'h1b,
      5'h02, 5'h09, 5'h15, 5'h1a, 5'h14, 5'h1f, 5'h0b, 5'h04
   };

endpackage

// File: rtl/sbox_lut_loader.sv
// Programs an N_ENTRIES x 5-bit S-box LUT over a register bus, one entry per
// transfer. Define SBOX_LOADER_READBACK_EN to add a read-and-compare pass after
// the write pass; without it the loader finishes after the writes and
// mismatch_o is tied low. A bus error ends the run early with err_o set.
module sbox_lut_loader
   import reg_pkg::*;
   import sbox_lut_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned N_ENTRIES   = 32,
   parameter int unsigned ADDR_STRIDE = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [N_ENTRIES*5-1:0] tbl_i,
   output reg_req_t               reg_req_o,
   input  reg_rsp_t               reg_rsp_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   output logic                   mismatch_o
);

   localparam int unsigned IdxW = $clog2(N_ENTRIES);
   // One spare bit so the counter never wraps before the terminal compare.
   localparam int unsigned CntW = IdxW + 1;

   loader_state_e                state_q, state_d;
   logic [CntW-1:0]              cnt_q, cnt_d;
   logic [N_ENTRIES-1:0][4:0]    tbl_q, tbl_d;
   logic                         err_q, err_d;
   logic [4:0]                   cur_entry;
   logic [31:0]                  cur_addr;
   logic                         last_entry;
`ifdef SBOX_LOADER_READBACK_EN
   logic                         mism_q, mism_d;
`endif

   // Only rdata[4:0] matters, and only with readback built in.
   logic unused_rdata;
   assign unused_rdata = ^reg_rsp_i.rdata;

   assign cur_entry  = tbl_q[cnt_q[IdxW-1:0]];
   assign cur_addr   = BASE_ADDR + 32'(cnt_q) * ADDR_STRIDE;
   assign last_entry = (cnt_q == CntW'(N_ENTRIES - 1));
   assign err_o      = err_q;
`ifdef SBOX_LOADER_READBACK_EN
   assign mismatch_o = mism_q;
`else
   assign mismatch_o = 1'b0;
`endif

   // Next-state, bus request and status outputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tbl_d     = tbl_q;
      err_d     = err_q;
`ifdef SBOX_LOADER_READBACK_EN
      mism_d    = mism_q;
`endif
      reg_req_o = '0;
      busy_o    = 1'b0;
      done_o    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               tbl_d   = tbl_i;
               err_d   = 1'b0;
`ifdef SBOX_LOADER_READBACK_EN
               mism_d  = 1'b0;
`endif
               cnt_d   = '0;
               state_d = StWrite;
            end
         end
         StWrite: begin
            busy_o          = 1'b1;
            reg_req_o.valid = 1'b1;
            reg_req_o.write = 1'b1;
            reg_req_o.addr  = cur_addr;
            reg_req_o.wdata = {27'b0, cur_entry};
            reg_req_o.wstrb = 4'hF;
            if (reg_rsp_i.ready) begin
               if (reg_rsp_i.error) begin
                  err_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = StDone;
               end else if (last_entry) begin
                  cnt_d   = '0;
`ifdef SBOX_LOADER_READBACK_EN
                  state_d = StRead;
`else
                  state_d = StDone;
`endif
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
`ifdef SBOX_LOADER_READBACK_EN
         StRead: begin
            busy_o          = 1'b1;
            reg_req_o.valid = 1'b1;
            reg_req_o.addr  = cur_addr;
            if (reg_rsp_i.ready) begin
               if (reg_rsp_i.error) begin
                  err_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = StDone;
               end else begin
                  if (reg_rsp_i.rdata[4:0] != cur_entry) begin
                     mism_d = 1'b1;
                  end
                  if (last_entry) begin
                     cnt_d   = '0;
                     state_d = StDone;
                  end else begin
                     cnt_d = cnt_q + CntW'(1);
                  end
               end
            end
         end
`endif
         StDone: begin
            done_o  = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         tbl_q   <= '0;
         err_q   <= 1'b0;
`ifdef SBOX_LOADER_READBACK_EN
         mism_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tbl_q   <= tbl_d;
         err_q   <= err_d;
`ifdef SBOX_LOADER_READBACK_EN
         mism_q  <= mism_d;
`endif
      end
   end

endmodule

// File: tb/tb_sbox_lut_loader.sv
// Randomized bench for sbox_lut_loader. Expectations follow the loader's
// transfer sequence rules; SBOX_LOADER_READBACK_EN selects the readback model.
module tb_sbox_lut_loader;
   import reg_pkg::*;
   import sbox_lut_loader_pkg::*;

   localparam int unsigned N      = 32;
   localparam logic [31:0] Base   = 32'h0000_0000;
   localparam int unsigned Stride = 4;
`ifdef SBOX_LOADER_READBACK_EN
   localparam bit Readback = 1'b1;
`else
   localparam bit Readback = 1'b0;
`endif

   typedef struct packed {
      logic        write;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } xfer_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [N*5-1:0] tbl;
   reg_req_t       req;
   reg_rsp_t       rsp;
   logic           busy, done, err, mism;
   logic [4:0]     mem [N];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sbox_lut_loader #(
      .BASE_ADDR   (Base),
      .N_ENTRIES   (N),
      .ADDR_STRIDE (Stride)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .tbl_i      (tbl),
      .reg_req_o  (req),
      .reg_rsp_i  (rsp),
      .busy_o     (busy),
      .done_o     (done),
      .err_o      (err),
      .mismatch_o (mism)
   );

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N*5-1:0] rand_table();
      logic [N*5-1:0] t;
      for (int i = 0; i < int'(N); i++) t[5*i +: 5] = 5'($urandom_range(0, 31));
      return t;
   endfunction

   // One full load. err_at: sequence index of the transfer answered with
   // error (-1 none); mism_entry: read entry answered with 0x1F (-1 none).
   task automatic run_op(input logic [N*5-1:0] table_v, input int ready_pct, input int err_at,
                         input int mism_entry, input bit hold_start, input string name);
      xfer_t    exp_q[$];
      xfer_t    obs_q[$];
      xfer_t    x;
      int       total, done_cyc, e, n;
      bit       exp_err, exp_mism, prev_stall, rdy, er;
      reg_req_t prev_req;
      logic [31:0] r, rdata;

      total    = Readback ? int'(2 * N) : int'(N);
      exp_err  = 1'b0;
      exp_mism = 1'b0;
      for (int k = 0; k < total; k++) begin
         e       = k % int'(N);
         x.write = (k < int'(N));
         x.addr  = Base + 32'(e) * Stride;
         x.wdata = x.write ? {27'b0, table_v[5*e +: 5]} : 32'h0;
         x.wstrb = x.write ? 4'hF : 4'h0;
         exp_q.push_back(x);
         if (k == err_at) begin
            exp_err = 1'b1;
            break;
         end
         if (!x.write && e == mism_entry && table_v[5*e +: 5] != 5'h1F) exp_mism = 1'b1;
      end

      tbl        = table_v;
      start      = 1'b1;
      rsp        = '0;
      prev_stall = 1'b0;
      prev_req   = '0;
      done_cyc   = -1;
      for (int cyc = 1; cyc <= 2000; cyc++) begin
         @(negedge clk);
         if (!hold_start) start = 1'b0;
         if (cyc == 1) begin
            check_val({name, "_err_cleared"}, 128'(err), 128'(0));
            check_val({name, "_mism_cleared"}, 128'(mism), 128'(0));
         end
         if (prev_stall) check_val({name, "_stall_stable"}, 128'(req), 128'(prev_req));
         if (done) begin
            done_cyc = cyc;
            check_val({name, "_done_req_idle"}, 128'(req), 128'(0));
            check_val({name, "_done_busy"}, 128'(busy), 128'(0));
            break;
         end
         check_val({name, "_busy"}, 128'(busy), 128'(1));
         if (req.valid) begin
            rdy   = (int'($urandom_range(0, 99)) < ready_pct);
            er    = rdy && (obs_q.size() == err_at);
            e     = int'((req.addr - Base) / Stride);
            r     = $urandom();
            rdata = {r[31:5], 5'h00};
            if (e >= 0 && e < int'(N)) begin
               if (!req.write) rdata = (e == mism_entry) ? 32'h1F : {r[31:5], mem[e]};
               else if (rdy) mem[e] = req.wdata[4:0];
            end
            if (rdy) begin
               x.write = req.write;
               x.addr  = req.addr;
               x.wdata = req.wdata;
               x.wstrb = req.wstrb;
               obs_q.push_back(x);
            end
            rsp        = '{rdata: rdata, error: er, ready: rdy};
            prev_stall = !rdy;
            prev_req   = req;
         end else begin
            rsp        = '0;
            prev_stall = 1'b0;
         end
      end
      rsp = '0;
      if (done_cyc < 0) check_val({name, "_done_timeout"}, 128'(0), 128'(1));

      check_val({name, "_n_xfer"}, 128'(obs_q.size()), 128'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check_val($sformatf("%s_xfer%0d", name, i), 128'(obs_q[i]), 128'(exp_q[i]));
      if (ready_pct >= 100 && done_cyc > 0)
         check_val({name, "_done_cycle"}, 128'(done_cyc), 128'(exp_q.size() + 1));

      // start may still be high across the DONE edge; it must be ignored there.
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check_val({name, "_err_o"}, 128'(err), 128'(exp_err));
      check_val({name, "_mismatch_o"}, 128'(mism), 128'(exp_mism));
      check_val({name, "_idle_busy"}, 128'(busy), 128'(0));
      check_val({name, "_idle_req"}, 128'(req), 128'(0));
      check_val({name, "_idle_done"}, 128'(done), 128'(0));
   endtask

   // start held high through the run, reset while entry 7 is on the bus.
   task automatic run_reset_mid();
      int n_xfer, n_done, bad_valid, bad_done;
      bit hit;
      tbl    = AsconSbox;
      start  = 1'b1;
      rsp    = '0;
      n_xfer = 0;
      n_done = 0;
      hit    = 1'b0;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         @(negedge clk);
         if (done) n_done++;
         if (req.valid && req.write && req.addr == Base + 7 * Stride) begin
            rsp = '0;
            rst = 1'b1;
            hit = 1'b1;
            break;
         end
         if (req.valid) begin
            check_val($sformatf("rst_wdata%0d", n_xfer), 128'(req.wdata),
                      128'({27'b0, AsconSbox[5*n_xfer +: 5]}));
            n_xfer++;
            rsp = '{rdata: 32'h0, error: 1'b0, ready: 1'b1};
         end else begin
            rsp = '0;
         end
      end
      check_val("rst_hit_entry7", 128'(hit), 128'(1));
      check_val("rst_pre_xfers", 128'(n_xfer), 128'(7));
      check_val("rst_pre_done", 128'(n_done), 128'(0));
      @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check_val("rst_valid_dropped", 128'(req.valid), 128'(0));
      check_val("rst_req_zero", 128'(req), 128'(0));
      check_val("rst_busy", 128'(busy), 128'(0));
      bad_valid = 0;
      bad_done  = 0;
      repeat (6) begin
         if (req.valid) bad_valid++;
         if (done) bad_done++;
         @(negedge clk);
      end
      check_val("rst_no_second_run", 128'(bad_valid), 128'(0));
      check_val("rst_no_done", 128'(bad_done), 128'(0));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [N*5-1:0] t;
      rst   = 1'b1;
      start = 1'b1;
      rsp   = '0;
      tbl   = AsconSbox;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("reset_req", 128'(req), 128'(0));
      check_val("reset_busy", 128'(busy), 128'(0));
      check_val("reset_done", 128'(done), 128'(0));
      check_val("reset_err", 128'(err), 128'(0));
      check_val("reset_mism", 128'(mism), 128'(0));
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);

      run_op(AsconSbox, 100, -1, -1, 1'b0, "ascon");
      for (int i = 0; i < 3; i++) begin
         run_op(rand_table(), 50, -1, -1, i[0], $sformatf("rand%0d", i));
      end
      t = rand_table();
      if (t[25 +: 5] == 5'h1F) t[25 +: 5] = 5'h0A;
      run_op(t, 100, -1, 5, 1'b0, "mism5");
      run_op(AsconSbox, 100, 10, -1, 1'b1, "err_w10");
      run_op(rand_table(), 50, int'(N) + int'($urandom_range(0, N - 1)), -1, 1'b0, "err_rd");
      run_reset_mid();
      run_op(AsconSbox, 50, -1, -1, 1'b0, "recover");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
